// File: rtl/regbank_reader.sv
// Snapshot reader for the register bank: captures all registers on start, then streams
// an index range out over a valid/ready interface, one register per accepted beat.
module regbank_reader #(
    parameter int unsigned n     = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [n*NREGS-1:0]   regs_flat,
    input  logic                 start,
    input  logic [IDXW-1:0]      first_idx,
    input  logic [IDXW-1:0]      last_idx,
    output logic [n-1:0]         out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     cur_q, cur_d;
    logic [IDXW-1:0]     end_q, end_d;
    logic [n*NREGS-1:0]  snap_q, snap_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cur_q   <= '0;
            end_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            snap_q  <= snap_d;
        end
    end

    // Outputs decode from state_q only, so an async reset clears them immediately.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        end_d     = end_q;
        snap_d    = snap_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d  = regs_flat;
                    cur_d   = first_idx;
                    end_d   = last_idx;
                    state_d = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = snap_q[cur_q*n +: n];
                out_idx   = cur_q;
                out_last  = (cur_q == end_q);
                if (out_ready) begin
                    if (cur_q == end_q) begin
                        state_d = StDone;
                    end else begin
                        // IDXW bits span exactly NREGS, so the add wraps NREGS-1 -> 0.
                        cur_d = cur_q + IDXW'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_regbank_reader.sv
// Scoreboard bench for regbank_reader: expected beats are queued at start and compared
// as the DUT hands them over.
module tb_regbank_reader;

    localparam int unsigned N     = 16;
    localparam int unsigned NREGS = 8;
    localparam int unsigned IDXW  = 3;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [N-1:0]    data;
        logic            last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [N*NREGS-1:0]   regs_flat;
    logic                 start;
    logic [IDXW-1:0]      first_idx;
    logic [IDXW-1:0]      last_idx;
    logic [N-1:0]         out_data;
    logic [IDXW-1:0]      out_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    regbank_reader #(
        .n     (N),
        .NREGS (NREGS),
        .IDXW  (IDXW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .regs_flat (regs_flat),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    beat_t       sb[$];
    logic [N-1:0] model_regs [NREGS];
    logic        ready_pat [6];

    int unsigned beat_cnt = 0;
    int unsigned done_cnt = 0;
    logic        done_expect = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [N-1:0] prev_data = '0;
    logic [IDXW-1:0] prev_idx = '0;
    logic        prev_last = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs();
        for (int k = 0; k < NREGS; k++) regs_flat[k*N +: N] = model_regs[k];
    endtask

    // Drives a start pulse for one edge and queues the beats it should produce.
    task automatic do_start(input logic [IDXW-1:0] f, input logic [IDXW-1:0] l);
        logic [IDXW-1:0] k;
        logic [IDXW-1:0] span;
        int nb;
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        span = l - f;
        nb   = int'(span) + 1;
        k    = f;
        for (int i = 0; i < nb; i++) begin
            sb.push_back('{idx: k, data: model_regs[k], last: (i == nb - 1)});
            k = k + 1'b1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned done_base,
                             input int unsigned beat_base, input int unsigned nbeats);
        for (int c = 0; c < 60 && done_cnt == done_base; c++) tick();
        tick();
        check_eq({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check_eq({tag, "_beats"}, beat_cnt - beat_base, nbeats);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
        check_eq({tag, "_idle_valid"}, {31'd0, out_valid}, 0);
        check_eq({tag, "_idle_busy"}, {31'd0, busy}, 0);
    endtask

    always @(negedge clk) begin
        beat_t exp_b;
        logic  hs;
        if (!resetn) begin
            done_expect = 1'b0;
            prev_valid  = 1'b0;
            prev_hs     = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            check_eq("done", {31'd0, done}, {31'd0, done_expect});
            if (done) done_cnt++;
            check_eq("busy_vs_valid", {31'd0, busy}, {31'd0, out_valid});
            if (prev_valid && !prev_hs) begin
                check_eq("stall_valid", {31'd0, out_valid}, 1);
                check_eq("stall_data", {16'd0, out_data}, {16'd0, prev_data});
                check_eq("stall_idx", {29'd0, out_idx}, {29'd0, prev_idx});
                check_eq("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (hs) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", {29'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = sb.pop_front();
                    check_eq("beat_idx", {29'd0, out_idx}, {29'd0, exp_b.idx});
                    check_eq("beat_data", {16'd0, out_data}, {16'd0, exp_b.data});
                    check_eq("beat_last", {31'd0, out_last}, {31'd0, exp_b.last});
                end
            end
            done_expect = hs && out_last;
            prev_valid  = out_valid;
            prev_hs     = hs;
            prev_data   = out_data;
            prev_idx    = out_idx;
            prev_last   = out_last;
        end
    end

    initial begin
        int unsigned d0;
        int unsigned b0;
        ready_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < NREGS; k++) model_regs[k] = 16'h1000 + 16'(k);
        load_regs();
        resetn    = 1'b0;
        start     = 1'b0;
        first_idx = '0;
        last_idx  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 0);
        check_eq("rst_data", {16'd0, out_data}, 0);
        check_eq("rst_idx", {29'd0, out_idx}, 0);
        check_eq("rst_last", {31'd0, out_last}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Full bank in order.
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd0, 3'd7);
        check_eq("first_beat_valid", {31'd0, out_valid}, 1);
        wait_done("full", d0, b0, 8);

        // Snapshot must ignore register changes after the start edge.
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd2, 3'd4);
        regs_flat = '1;
        wait_done("snap", d0, b0, 3);
        load_regs();

        // Backpressure.
        d0 = done_cnt; b0 = beat_cnt;
        out_ready = 1'b0;
        do_start(3'd1, 3'd3);
        for (int i = 0; i < 6; i++) begin
            out_ready = ready_pat[i];
            tick();
        end
        out_ready = 1'b1;
        check_eq("bp_beats_after_pattern", beat_cnt - b0, 3);
        wait_done("bp", d0, b0, 3);

        // Wrap-around, single beat, and full bank starting mid-range.
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd6, 3'd1);
        wait_done("wrap", d0, b0, 4);
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd5, 3'd5);
        wait_done("single", d0, b0, 1);
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd3, 3'd2);
        wait_done("fullwrap", d0, b0, 8);

        // Start pulses while busy and on the done cycle must be ignored.
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd0, 3'd3);
        first_idx = 3'd5;
        last_idx  = 3'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("busy_start_done_cycle", {31'd0, done}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_start_idle_valid", {31'd0, out_valid}, 0);
        tick();
        check_eq("busy_start_still_idle", {31'd0, busy}, 0);
        check_eq("busy_start_beats", beat_cnt - b0, 4);
        check_eq("busy_start_dones", done_cnt - d0, 1);

        // Asynchronous abort mid-readout.
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd0, 3'd7);
        tick();
        tick();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 0);
        check_eq("abort_busy", {31'd0, busy}, 0);
        check_eq("abort_done", {31'd0, done}, 0);
        check_eq("abort_data", {16'd0, out_data}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_no_done", {31'd0, done}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_eq("abort_dones", done_cnt - d0, 0);
        d0 = done_cnt; b0 = beat_cnt;
        do_start(3'd4, 3'd5);
        wait_done("post_abort", d0, b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
